// File: rtl/serializador_matriz.sv
// serializador_matriz
// Captures a packed DIM x DIM matrix of signed ELEM_W-bit elements and
// streams it out one element per valid/ready handshake, in linear order
// k = linha*DIM + coluna.
//
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   start       : capture matriz_in and begin a stream (honoured in IDLE only)
//   matriz_in   : packed matrix, element k at [k*ELEM_W +: ELEM_W]
//   elem_out    : current element (signed, bit-exact copy of the source slice)
//   elem_idx    : linear index k of elem_out
//   linha/coluna: row/column of elem_out
//   elem_valid  : elem_out/elem_idx/linha/coluna are valid
//   elem_ready  : sink accepts the element this cycle
//   busy        : high while streaming and during the done cycle
//   done        : one-cycle pulse after the last element is accepted
//
// Handshake: an element transfers at a rising edge where elem_valid and
// elem_ready are both 1. While elem_valid=1 and elem_ready=0 every data
// output holds; elem_ready has no effect while elem_valid=0.
module serializador_matriz #(
  parameter int DIM    = 5,
  parameter int ELEM_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DIM*DIM*ELEM_W-1:0]     matriz_in,
  output logic signed [ELEM_W-1:0]      elem_out,
  output logic [$clog2(DIM*DIM)-1:0]    elem_idx,
  output logic [2:0]                    linha,
  output logic [2:0]                    coluna,
  output logic                          elem_valid,
  input  logic                          elem_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int N_ELEM = DIM * DIM;
  localparam int IDX_W  = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q, state_n;
  logic [N_ELEM*ELEM_W-1:0]   shadow_q, shadow_n;
  logic signed [ELEM_W-1:0]   elem_out_n;
  logic [IDX_W-1:0]           idx_n;
  logic [2:0]                 linha_n, coluna_n;
  logic                       valid_n, busy_n, done_n;

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_n    = state_q;
    shadow_n   = shadow_q;
    elem_out_n = elem_out;
    idx_n      = elem_idx;
    linha_n    = linha;
    coluna_n   = coluna;
    valid_n    = elem_valid;
    busy_n     = busy;
    done_n     = 1'b0;

    case (state_q)
      IDLE: begin
        elem_out_n = '0;
        idx_n      = '0;
        linha_n    = '0;
        coluna_n   = '0;
        valid_n    = 1'b0;
        busy_n     = 1'b0;
        if (start) begin
          // The stream reads only the shadow copy from here on, so later
          // changes on matriz_in cannot leak into it.
          shadow_n   = matriz_in;
          elem_out_n = matriz_in[ELEM_W-1:0];
          valid_n    = 1'b1;
          busy_n     = 1'b1;
          state_n    = SEND;
        end
      end

      SEND: begin
        if (elem_valid && elem_ready) begin
          if (elem_idx == IDX_W'(N_ELEM - 1)) begin
            valid_n = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            idx_n      = elem_idx + IDX_W'(1);
            elem_out_n = shadow_q[32'(idx_n) * ELEM_W +: ELEM_W];
            if (coluna == 3'(DIM - 1)) begin
              coluna_n = '0;
              linha_n  = linha + 3'd1;
            end else begin
              coluna_n = coluna + 3'd1;
            end
          end
        end
      end

      DONE: begin
        // Single cycle with done=1, busy=1; start is not looked at here.
        elem_out_n = '0;
        idx_n      = '0;
        linha_n    = '0;
        coluna_n   = '0;
        valid_n    = 1'b0;
        busy_n     = 1'b0;
        state_n    = IDLE;
      end

      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      elem_out   <= '0;
      elem_idx   <= '0;
      linha      <= '0;
      coluna     <= '0;
      elem_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_n;
      shadow_q   <= shadow_n;
      elem_out   <= elem_out_n;
      elem_idx   <= idx_n;
      linha      <= linha_n;
      coluna     <= coluna_n;
      elem_valid <= valid_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: doc/serializador_matriz.md
Name: serializador_matriz

Overview:
- Reads a packed 5x5 signed 8-bit matrix, the same 200-bit bus format that the matrix-operation blocks (e.g. oposicao_matriz) produce.
- Streams the 25 elements out one per handshake over a valid/ready interface.
- Sits downstream of a matrix operation: it is the reader/consumer end of the parallel matrix bus, feeding narrow sinks such as a UART/LCD formatter or a memory writer.

Parameters:
- DIM, 5, matrix dimension (DIM x DIM elements).
- ELEM_W, 8, element width in bits, two's complement.
- N_ELEM, DIM*DIM (25), derived element count; not overridden independently.
- IDX_W, $clog2(N_ELEM) (5), derived width of the element index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to capture matriz_in and stream it; sampled only in IDLE.
- matriz_in  in  N_ELEM*ELEM_W (200)  packed matrix; element k at bits [k*ELEM_W +: ELEM_W], k = linha*DIM + coluna.
- elem_out  out  ELEM_W (8), signed  current element.
- elem_idx  out  IDX_W (5)  linear index k of elem_out.
- linha  out  3  row of elem_out (0..DIM-1).
- coluna  out  3  column of elem_out (0..DIM-1).
- elem_valid  out  1  elem_out, elem_idx, linha and coluna are valid.
- elem_ready  in  1  sink accepts the element this cycle.
- busy  out  1  high in SEND and DONE.
- done  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- All outputs are registered.
- Reset (synchronous, applied at the clk edge):
  - state goes to IDLE.
  - elem_out, elem_idx, linha, coluna, elem_valid, busy and done all go to 0.
  - The shadow register is cleared.
  - Reset wins over every other input in the same cycle.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - When start=1 at an edge: capture matriz_in into the shadow register; set idx=0, linha=0, coluna=0; elem_out = shadow element 0; set elem_valid=1 and busy=1; go to SEND.
  - Latency: the first element is visible 1 cycle after start is sampled.
  - With start=0, all outputs hold at 0 / inactive.
- SEND:
  - A handshake occurs at an edge where elem_valid=1 and elem_ready=1.
  - Handshake with idx < N_ELEM-1:
    - idx increments and elem_out loads the next element from the shadow register.
    - coluna increments; when coluna wraps from DIM-1 to 0, linha increments.
    - elem_valid stays 1, so one element per cycle is possible under continuous ready.
  - Handshake with idx = N_ELEM-1: elem_valid goes to 0, done goes to 1, state goes to DONE.
  - With elem_valid=1 and elem_ready=0: all data outputs hold stable (no bubble, no skip).
- DONE:
  - Lasts exactly one cycle, with done=1 and busy=1.
  - Next state is IDLE, where done and busy return to 0.
- start is ignored in SEND and DONE; it is not queued.
- Data isolation: the shadow register is frozen after capture, so changes on matriz_in during SEND do not affect the output stream.
- Arithmetic: no transformation is applied; elem_out is bit-exact with the source slice and keeps its sign (e.g. 8'hE7 = -25).
- Reset mid-stream: the stream is abandoned, with no done pulse. A following start streams again from element 0.
- elem_ready while elem_valid=0 has no effect.

Test Plan:
- Positive matrix: element k = k+1, start pulse, elem_ready held at 1.
  - elem_out = 1..25 on 25 consecutive cycles starting 1 cycle after start.
  - (linha, coluna) runs (0,0)..(4,4), with coluna wrapping at 4.
  - done pulses once, the cycle after element 25 is accepted; busy is high for 26 cycles.
- Negative matrix: element k = -(k+1), elem_ready held at 1.
  - elem_out is read signed as -1..-25; the last element is 8'hE7.
- Backpressure: elem_ready low for 3 cycles while elem_idx=6.
  - elem_out holds 7, elem_idx holds 6, elem_valid stays 1.
  - Streaming resumes with 8 after ready rises; the total element count is still 25.
- Isolation / start while busy: positive matrix started, then matriz_in set to all 0x7F and start pulsed at elem_idx=3.
  - The stream still delivers 1..25 with a single done pulse.
- Reset mid-stream: reset pulsed while elem_idx=10.
  - The next cycle shows elem_valid=0, busy=0, done=0, elem_out=0.
  - A following start restarts at elem_out=1, elem_idx=0.
- Back-to-back runs: start asserted in the first IDLE cycle after DONE.
  - It is accepted and the second stream begins 1 cycle later.
  - Exactly one done pulse is produced per run.
